// File: rtl/uart_tx_framer.sv
// 8N1 UART transmit framer: latches a byte on byte_ready, sends it on t_byte,
// and holds done until byte_ready is released.
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       byte_ready,
  input  logic       t_byte,
  output logic       tx,
  output logic       done,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          bit_end_s;

  assign bit_end_s = (cnt_q == CNT_MAX);

  // Next-state and next-output computation; outputs are computed one edge ahead
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    tx_d    = tx_q;
    done_d  = done_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        cnt_d = {CW{1'b0}};
        if (byte_ready) begin
          shift_d = data_in;
          if (t_byte) begin
            state_d = START;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = DATA;
          cnt_d   = {CW{1'b0}};
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_d = {CW{1'b0}};
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // The next bit to drive is the one about to land in shift_q[0]
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            idx_d   = idx_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          state_d = DONE;
          cnt_d   = {CW{1'b0}};
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = STOP;
        end
      end
      DONE: begin
        cnt_d = {CW{1'b0}};
        if (!byte_ready) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
        idx_d   = 3'd0;
        tx_d    = 1'b1;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= 8'h00;
      cnt_q   <= {CW{1'b0}};
      idx_q   <= 3'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer at CLKS_PER_BIT=4: directed scenarios
// plus randomized frames checked against an arithmetic model of the 8N1 line.
module tb_uart_tx_framer;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       byte_ready;
  logic       t_byte;
  logic       tx;
  logic       done;
  logic       busy;

  int tests;
  int fails;

  uart_tx_framer #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .byte_ready (byte_ready),
    .t_byte     (t_byte),
    .tx         (tx),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare {tx, busy, done} against the expected triple
  task automatic chk(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {tx, busy, done};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: {tx,busy,done} got %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected line level for cycle k of a frame carrying byte d
  function automatic logic line_bit(input logic [7:0] d, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return (d >> (b - 1)) & 8'h01 ? 1'b1 : 1'b0;
  endfunction

  // Run one frame whose start request is already on the inputs
  task automatic frame(input string tag, input logic [7:0] d, input int chg_at,
                       input logic [7:0] chg_val, input int drop_at);
    int w;
    tick();
    w = 0;
    while (tx !== 1'b0 && w < 4) begin
      tick();
      w++;
    end
    chk({tag, "_start"}, {1'b0, 1'b1, 1'b0});
    if (tx !== 1'b0) return;
    for (int k = 0; k < 10 * CPB; k++) begin
      chk($sformatf("%s_c%0d", tag, k), {line_bit(d, k), 1'b1, 1'b0});
      if (k == chg_at) data_in = chg_val;
      if (k == drop_at) byte_ready = 1'b0;
      tick();
    end
    chk({tag, "_done"}, 3'b101);
    if (byte_ready) begin
      tick();
      chk({tag, "_done_hold"}, 3'b101);
      byte_ready = 1'b0;
    end
    t_byte = 1'b0;
    tick();
    chk({tag, "_done_clr"}, 3'b100);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst_n      = 1'b0;
    data_in    = 8'h00;
    byte_ready = 1'b0;
    t_byte     = 1'b0;
    tick();
    tick();
    chk("reset", 3'b100);

    // Reset wins over a start request
    byte_ready = 1'b1;
    t_byte     = 1'b1;
    data_in    = 8'h55;
    tick();
    chk("reset_prio", 3'b100);
    byte_ready = 1'b0;
    t_byte     = 1'b0;
    rst_n      = 1'b1;
    tick();
    chk("idle", 3'b100);

    // Single byte 0xA5, then hold byte_ready through DONE for 5 cycles
    data_in    = 8'hA5;
    byte_ready = 1'b1;
    t_byte     = 1'b1;
    tick();
    for (int k = 0; k < 10 * CPB; k++) begin
      chk($sformatf("a5_c%0d", k), {line_bit(8'hA5, k), 1'b1, 1'b0});
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("a5_hold%0d", k), 3'b101);
      tick();
    end
    byte_ready = 1'b0;
    tick();
    chk("a5_release", 3'b100);

    // t_byte without byte_ready is ignored
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("tbyte_only%0d", k), 3'b100);
    end
    t_byte = 1'b0;

    // Load only, then send with a newer byte
    byte_ready = 1'b1;
    data_in    = 8'h3C;
    tick();
    tick();
    chk("load_only", 3'b100);
    data_in = 8'hFF;
    t_byte  = 1'b1;
    frame("load_send", 8'hFF, -1, 8'h00, -1);

    // Data change during frame bit 3 must not disturb the frame
    data_in    = 8'h00;
    byte_ready = 1'b1;
    t_byte     = 1'b1;
    frame("data_chg", 8'h00, 3 * CPB, 8'hFF, -1);

    // byte_ready dropped during START: single-cycle done
    data_in    = 8'h6E;
    byte_ready = 1'b1;
    t_byte     = 1'b1;
    frame("drop_early", 8'h6E, -1, 8'h00, 1);

    // Reset during bit 5 aborts the frame
    data_in    = 8'h5A;
    byte_ready = 1'b1;
    t_byte     = 1'b1;
    tick();
    for (int k = 0; k < 5 * CPB + 1; k++) tick();
    rst_n      = 1'b0;
    byte_ready = 1'b0;
    t_byte     = 1'b0;
    tick();
    chk("rst_mid", 3'b100);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst_after%0d", k), 3'b100);
    end
    data_in    = 8'h81;
    byte_ready = 1'b1;
    t_byte     = 1'b1;
    frame("after_rst", 8'h81, -1, 8'h00, -1);

    // Randomized frames with random mid-frame data changes and drops
    for (int r = 0; r < 6; r++) begin
      logic [7:0] d;
      logic [7:0] cv;
      int         chg;
      int         drop;
      int         gap;
      gap  = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick();
      d    = 8'($urandom);
      cv   = 8'($urandom);
      chg  = int'($urandom_range(0, 10 * CPB - 1));
      drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10 * CPB - 1)) : -1;
      data_in    = d;
      byte_ready = 1'b1;
      t_byte     = 1'b1;
      frame($sformatf("rnd%0d", r), d, chg, cv, drop);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
